axis_arb2: RTL and testbench
============================

AXIS_ARB2 -- requirements
Module: axis_arb2

Interface
REQ-001 SHALL have parameter OUT_REG, default 1: 1 registers the output (one-cycle latency); 0 makes the path combinational.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port axis_sif0, axis_if.s, width TDATA_WIDTH: subordinate input stream 0.
REQ-005 SHALL have port axis_sif1, axis_if.s, width TDATA_WIDTH: subordinate input stream 1.
REQ-006 SHALL have port axis_mif, axis_if.m, width TDATA_WIDTH: merged manager output, normally driving an axis_sync_fifo subordinate.
REQ-007 SHALL have port src_id, output, 1 bit: index of the input that produced the beat currently on axis_mif.
REQ-008 SHALL have port invalidate, input, 1 bit: flush request.
REQ-009 SHALL take TDATA_WIDTH from axis_mif and SHALL fail elaboration ($fatal) if either subordinate width differs.

Function
REQ-010 With OUT_REG=1, the block SHALL hold output state tvalid_q, tdata_q and src_q, and SHALL drive axis_mif.tvalid/tdata and src_id from them.
REQ-011 With OUT_REG=1, accept = !tvalid_q || axis_mif.tready, so a full-throughput pipeline is possible with no bubble.
REQ-012 When accept=1, grant SHALL go to the single valid input, or to the input selected by the priority pointer prio_q when both inputs are valid.
REQ-013 axis_sifN.tready SHALL equal accept && grant==N && !invalidate, so only the granted input ever sees tready=1.
REQ-014 On an input handshake, tdata_q <= input tdata, src_q <= N and tvalid_q <= 1 on the next edge.
REQ-015 When accept=1 and no input is valid, tvalid_q <= 0.
REQ-016 prio_q SHALL update only on an input handshake, to the input not just granted.
REQ-017 A beat held with tvalid_q=1 and axis_mif.tready=0 SHALL keep tdata, tvalid and src_id stable.
REQ-018 The grant SHALL not change while the block is stalled; arbitration is re-evaluated each cycle but consumes nothing.
REQ-019 With OUT_REG=0, axis_mif.tvalid = (sif0.tvalid || sif1.tvalid) && !invalidate.
REQ-020 With OUT_REG=0, tdata and src_id SHALL be muxed from the granted input, and sifN.tready = axis_mif.tready && grant==N && !invalidate.
REQ-021 With OUT_REG=0, prio_q SHALL update on an output handshake.
REQ-022 invalidate=1 SHALL clear tvalid_q on the next edge, discarding any held beat.
REQ-023 invalidate=1 SHALL hold both input treadys at 0 in the same cycle.
REQ-024 invalidate=1 SHALL leave prio_q unchanged.
REQ-025 No beat SHALL be duplicated, dropped (except by invalidate) or reordered within one source.

Reset
REQ-026 rst_n=0 SHALL immediately force tvalid_q=0, tdata_q=0, src_q=0 and prio_q=0 (input 0 favoured).
REQ-027 During reset, axis_mif.tvalid=0, src_id=0 and both input treadys = 0.
REQ-028 Reset asserted mid-transfer SHALL drop the held beat; the first cycle after deassertion behaves as post-reset idle.

Configuration
REQ-029 Macro AXIS_ARB2_ROUND_ROBIN_EN defined: arbitration SHALL use prio_q round-robin as in REQ-012 and REQ-016.
REQ-030 Macro AXIS_ARB2_ROUND_ROBIN_EN undefined: input 0 SHALL always win when both inputs are valid, and prio_q SHALL not exist.

Structure
REQ-031 Shared package axis_pkg SHALL hold the typedef axis_src_t (1-bit enum SRC0/SRC1) and the localparam AXIS_ARB2_NUM_SRC=2.
REQ-032 Grant logic and prio_q SHALL live in sub-module rr_arb2, with inputs req[1:0] and advance, and output grant (axis_src_t).

Verification
REQ-033 After reset, only sif0 valid with tdata=0xA5 and mif.tready=1: mif.tvalid=1, tdata=0xA5, src_id=0 one cycle later (OUT_REG=1).
REQ-034 Both inputs continuously valid (sif0 0x10.., sif1 0x20..) with ROUND_ROBIN_EN: output alternates 0x10, 0x20, 0x11, 0x21, one beat per cycle.
REQ-035 Same stimulus as REQ-034 without the macro: output is only 0x10, 0x11, 0x12, and sif1.tready stays 0.
REQ-036 mif.tready=0 for 5 cycles with a beat 0x3C held: tdata and src_id stay stable, both treadys are 0, and 0x3C is delivered once tready returns.
REQ-037 invalidate pulsed while 0x55 is held: next cycle mif.tvalid=0, and 0x55 never appears.
REQ-038 rst_n asserted asynchronously mid-stream: mif.tvalid drops before the next clock edge, and after release the first grant goes to sif0.

Source files
------------

// File: rtl/axis_pkg.sv
// axis_pkg: shared source-index type and arbiter constants for the AXI-Stream blocks
package axis_pkg;
  typedef enum logic {SRC0 = 1'b0, SRC1 = 1'b1} axis_src_t;
  localparam int AXIS_ARB2_NUM_SRC = 2;
endpackage

// File: rtl/axis_if.sv
// axis_if: AXI-Stream valid/ready/data bundle with manager and subordinate views
interface axis_if #(parameter int TDATA_WIDTH = 8);
  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;
  modport m (output tvalid, output tdata, input tready);
  modport s (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_arb2_rr.sv
// rr_arb2: two-way grant logic; round-robin pointer only with AXIS_ARB2_ROUND_ROBIN_EN
module rr_arb2
  import axis_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [AXIS_ARB2_NUM_SRC-1:0] req,
  input  logic                         advance,
  output axis_src_t                    grant
);
`ifdef AXIS_ARB2_ROUND_ROBIN_EN
  axis_src_t prio_q;
  // Lone requester wins; on contention the pointer decides.
  always_comb grant = (req == 2'b10) ? SRC1 : (req == 2'b11) ? prio_q : SRC0;
  // After each consumed beat, favour the input that was not served.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prio_q <= SRC0;
    else if (advance) prio_q <= (grant == SRC0) ? SRC1 : SRC0;
`else
  logic unused_ok;
  assign unused_ok = ^{clk, rst_n, advance};
  // Fixed priority: input 0 always wins on contention.
  always_comb grant = (req == 2'b10) ? SRC1 : SRC0;
`endif
endmodule

// File: rtl/axis_arb2.sv
// axis_arb2: merges two AXI-Stream inputs into one; AXIS_ARB2_ROUND_ROBIN_EN selects round-robin over fixed priority
module axis_arb2
  import axis_pkg::*;
#(
  parameter bit OUT_REG = 1
) (
  input  logic clk,
  input  logic rst_n,
  axis_if.s    axis_sif0,
  axis_if.s    axis_sif1,
  axis_if.m    axis_mif,
  output logic src_id,
  input  logic invalidate
);
  localparam int W = $bits(axis_mif.tdata);
  if ($bits(axis_sif0.tdata) != W || $bits(axis_sif1.tdata) != W) begin : g_width_bad
    $fatal(1, "axis_arb2: subordinate tdata width differs from manager width");
  end
  logic [AXIS_ARB2_NUM_SRC-1:0] req;
  logic                         accept;
  logic                         advance;
  axis_src_t                    grant;
  assign req = {axis_sif1.tvalid, axis_sif0.tvalid};
  // Treadys are masked by reset so nothing is taken while the output state is forced idle.
  assign axis_sif0.tready = rst_n && accept && grant == SRC0 && !invalidate;
  assign axis_sif1.tready = rst_n && accept && grant == SRC1 && !invalidate;
  assign advance = (axis_sif0.tvalid && axis_sif0.tready) || (axis_sif1.tvalid && axis_sif1.tready);
  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .advance (advance),
    .grant   (grant)
  );
  if (OUT_REG) begin : g_reg
    logic         tvalid_q;
    logic [W-1:0] tdata_q;
    axis_src_t    src_q;
    assign accept = !tvalid_q || axis_mif.tready;
    // Output slot: load the granted beat when free, flush on invalidate, hold while stalled.
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        tvalid_q <= 1'b0;
        tdata_q  <= '0;
        src_q    <= SRC0;
      end else if (invalidate) begin
        tvalid_q <= 1'b0;
      end else if (accept) begin
        tvalid_q <= |req;
        if (|req) begin
          tdata_q <= (grant == SRC1) ? axis_sif1.tdata : axis_sif0.tdata;
          src_q   <= grant;
        end
      end
    assign axis_mif.tvalid = tvalid_q;
    assign axis_mif.tdata  = tdata_q;
    assign src_id          = src_q;
  end else begin : g_comb
    assign accept          = axis_mif.tready;
    assign axis_mif.tvalid = rst_n && (|req) && !invalidate;
    assign axis_mif.tdata  = (grant == SRC1) ? axis_sif1.tdata : axis_sif0.tdata;
    assign src_id          = rst_n && grant == SRC1;
  end
endmodule

// File: tb/tb_axis_arb2.sv
// tb_axis_arb2: directed checks of axis_arb2 (OUT_REG=1) in either arbitration build
module tb_axis_arb2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic invalidate = 1'b0;
  logic src_id;
  int   n_tests = 0;
  int   n_fail = 0;
  logic h0, h1;
  logic [7:0] d0, d1;
  logic [7:0] exp_seq [4];
  axis_if #(.TDATA_WIDTH(8)) s0_if ();
  axis_if #(.TDATA_WIDTH(8)) s1_if ();
  axis_if #(.TDATA_WIDTH(8)) m_if ();
  axis_arb2 #(.OUT_REG(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .axis_sif0  (s0_if),
    .axis_sif1  (s1_if),
    .axis_mif   (m_if),
    .src_id     (src_id),
    .invalidate (invalidate)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    s0_if.tvalid = 1'b0;
    s1_if.tvalid = 1'b0;
    invalidate = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  initial begin
    s0_if.tvalid = 1'b1; s0_if.tdata = 8'h00;
    s1_if.tvalid = 1'b1; s1_if.tdata = 8'h00;
    m_if.tready = 1'b1;
    #1;
    chk("rst_tvalid", m_if.tvalid, 0);
    chk("rst_src", src_id, 0);
    chk("rst_s0_tready", s0_if.tready, 0);
    chk("rst_s1_tready", s1_if.tready, 0);
    do_reset();
    // single beat from sif0
    s0_if.tvalid = 1'b1; s0_if.tdata = 8'hA5; m_if.tready = 1'b1;
    tick();
    s0_if.tvalid = 1'b0;
    chk("a5_tvalid", m_if.tvalid, 1);
    chk("a5_tdata", m_if.tdata, 8'hA5);
    chk("a5_src", src_id, 0);
    tick();
    chk("a5_drained", m_if.tvalid, 0);
    // both inputs streaming
    do_reset();
`ifdef AXIS_ARB2_ROUND_ROBIN_EN
    exp_seq = '{8'h10, 8'h20, 8'h11, 8'h21};
`else
    exp_seq = '{8'h10, 8'h11, 8'h12, 8'h13};
`endif
    d0 = 8'h10; d1 = 8'h20;
    s0_if.tvalid = 1'b1; s1_if.tvalid = 1'b1; m_if.tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s0_if.tdata = d0; s1_if.tdata = d1;
      #1;
      h0 = s0_if.tvalid && s0_if.tready;
      h1 = s1_if.tvalid && s1_if.tready;
`ifndef AXIS_ARB2_ROUND_ROBIN_EN
      chk("fixed_s1_tready", s1_if.tready, 0);
`endif
      tick();
      chk("stream_tvalid", m_if.tvalid, 1);
      chk("stream_tdata", m_if.tdata, exp_seq[i]);
      if (h0) d0++;
      if (h1) d1++;
    end
    s0_if.tvalid = 1'b0; s1_if.tvalid = 1'b0;
    tick();
    tick();
    // stall with 0x3C held
    m_if.tready = 1'b0;
    s0_if.tvalid = 1'b1; s0_if.tdata = 8'h3C;
    tick();
    s0_if.tdata = 8'h3D;
    s1_if.tvalid = 1'b1; s1_if.tdata = 8'h77;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_tvalid", m_if.tvalid, 1);
      chk("stall_tdata", m_if.tdata, 8'h3C);
      chk("stall_src", src_id, 0);
      chk("stall_s0_tready", s0_if.tready, 0);
      chk("stall_s1_tready", s1_if.tready, 0);
      tick();
    end
    s0_if.tvalid = 1'b0; s1_if.tvalid = 1'b0; m_if.tready = 1'b1;
    #1;
    chk("stall_release_tdata", m_if.tdata, 8'h3C);
    chk("stall_release_tvalid", m_if.tvalid, 1);
    tick();
    chk("stall_once", m_if.tvalid, 0);
    // invalidate a held 0x55
    m_if.tready = 1'b0;
    s0_if.tvalid = 1'b1; s0_if.tdata = 8'h55;
    tick();
    s0_if.tdata = 8'h56;
    invalidate = 1'b1;
    #1;
    chk("inv_held_tdata", m_if.tdata, 8'h55);
    tick();
    chk("inv_tvalid", m_if.tvalid, 0);
    chk("inv_s0_tready", s0_if.tready, 0);
    tick();
    chk("inv_hold_tvalid", m_if.tvalid, 0);
    invalidate = 1'b0; m_if.tready = 1'b1;
    #1;
    chk("inv_after_s0_tready", s0_if.tready, 1);
    tick();
    chk("inv_after_tvalid", m_if.tvalid, 1);
    chk("inv_after_tdata", m_if.tdata, 8'h56);
    s0_if.tvalid = 1'b0;
    tick();
    // asynchronous reset mid-stream
    s0_if.tvalid = 1'b1; s0_if.tdata = 8'h90;
    tick();
    chk("pre_rst_tdata", m_if.tdata, 8'h90);
    #2 rst_n = 1'b0;
    s0_if.tdata = 8'h91;
    s1_if.tvalid = 1'b1; s1_if.tdata = 8'hA1;
    #1;
    chk("async_rst_tvalid", m_if.tvalid, 0);
    chk("async_rst_tdata", m_if.tdata, 0);
    chk("async_rst_src", src_id, 0);
    chk("async_rst_s0_tready", s0_if.tready, 0);
    chk("async_rst_s1_tready", s1_if.tready, 0);
    #2 rst_n = 1'b1;
    #1;
    chk("post_rst_s0_tready", s0_if.tready, 1);
    chk("post_rst_s1_tready", s1_if.tready, 0);
    tick();
    chk("post_rst_tdata", m_if.tdata, 8'h91);
    chk("post_rst_src", src_id, 0);
    s0_if.tvalid = 1'b0; s1_if.tvalid = 1'b0;
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
